// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the RV32 hazard/forwarding scoreboard.
// Holds in-flight table entry layout and forward-select constants.
package hazard_scoreboard_pkg;

   // Widest register address / select a build may use.
   localparam int RA_W_MAX = 8;
   localparam int SELW_MAX = 4;

   // Select value meaning "take operand from the register file".
   localparam int FWD_REGFILE = 0;

   typedef logic [SELW_MAX-1:0] fwd_sel_t;

   typedef struct packed {
      logic                valid;
      logic [RA_W_MAX-1:0] rd;
      logic                is_load;
   } inflight_entry_t;

   function automatic int sel_width(input int num_fwd);
      return $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_priority_match.sv
// Priority matcher: finds the youngest in-flight producer of one source.
// Ports: rs/used in, tbl in; hit, k (stage index), is_load out.
module fwd_priority_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5,
   parameter int SELW    = 2
) (
   input  logic                          [RA_W-1:0] rs,
   input  logic                                     used,
   input  inflight_entry_t [NUM_FWD:1]              tbl,
   output logic                                     hit,
   output logic                          [SELW-1:0] k,
   output logic                                     is_load
);

   logic [RA_W_MAX-1:0] rs_x;

   assign rs_x = RA_W_MAX'(rs);

   // Scan oldest to youngest so the youngest match is left standing.
   always_comb begin
      hit     = 1'b0;
      k       = '0;
      is_load = 1'b0;
      if (used && (rs != '0)) begin
         for (int j = NUM_FWD; j >= 1; j--) begin
            if (tbl[j].valid && (tbl[j].rd == rs_x)) begin
               hit     = 1'b1;
               k       = SELW'(j);
               is_load = tbl[j].is_load;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: forward selects, load-use stall,
// redirect flush train. Optional perf counters under HAZARD_PERF_EN.
// Ports: clk, rst_n; id_* decode info, redirect in;
// fwd_sel, stall_id, flush_id, stall_count, flush_count out.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int NUM_SRC      = 2,
   parameter  int NUM_FWD      = 2,
   parameter  int LOAD_LAT     = 1,
   parameter  int FLUSH_CYCLES = 2,
   parameter  int RA_W         = 5,
   localparam int SELW         = sel_width(NUM_FWD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [NUM_SRC*RA_W-1:0] id_rs_addr,
   input  logic [NUM_SRC-1:0]      id_rs_used,
   input  logic [RA_W-1:0]         id_rd_addr,
   input  logic                    id_rd_we,
   input  logic                    id_is_load,
   input  logic                    redirect,
   output logic [NUM_SRC*SELW-1:0] fwd_sel,
   output logic                    stall_id,
   output logic                    flush_id,
   output logic [31:0]             stall_count,
   output logic [31:0]             flush_count
);

   if (LOAD_LAT < 1 || LOAD_LAT >= NUM_FWD) begin : g_bad_lat
      $error("hazard_scoreboard: need 1 <= LOAD_LAT < NUM_FWD");
   end
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
      $error("hazard_scoreboard: FLUSH_CYCLES must be 1..15");
   end
   if (RA_W > RA_W_MAX || SELW > SELW_MAX) begin : g_bad_w
      $error("hazard_scoreboard: RA_W or NUM_FWD too large");
   end

   // The redirect cycle is itself the first bubble.
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   inflight_entry_t [NUM_FWD:1] tbl;
   inflight_entry_t             new_ent;
   logic            [3:0]       flush_cnt;
   logic                        take;

   logic [NUM_SRC-1:0] hit;
   logic [NUM_SRC-1:0] ld;
   logic [NUM_SRC-1:0] lu;
   logic [SELW-1:0]    k_sel [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_priority_match #(
         .NUM_FWD (NUM_FWD),
         .RA_W    (RA_W),
         .SELW    (SELW)
      ) u_match (
         .rs      (id_rs_addr[i*RA_W +: RA_W]),
         .used    (id_rs_used[i]),
         .tbl     (tbl),
         .hit     (hit[i]),
         .k       (k_sel[i]),
         .is_load (ld[i])
      );

      assign fwd_sel[i*SELW +: SELW] =
         (hit[i] && id_valid) ? k_sel[i]
                              : SELW'(FWD_REGFILE);

      assign lu[i] = hit[i] & ld[i] &
                     (k_sel[i] <= SELW'(LOAD_LAT));
   end

   // Gated by rst_n so a redirect held during reset cannot flush.
   assign flush_id = rst_n & (redirect | (flush_cnt != 4'd0));
   assign stall_id = id_valid & ~flush_id & (|lu);

   assign take = id_valid & id_rd_we & (id_rd_addr != '0) &
                 ~stall_id & ~flush_id;

   always_comb begin
      new_ent         = '0;
      new_ent.valid   = take;
      new_ent.rd      = take ? RA_W_MAX'(id_rd_addr) : '0;
      new_ent.is_load = take & id_is_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl <= '0;
      end else begin
         for (int j = NUM_FWD; j >= 2; j--) begin
            tbl[j] <= tbl[j-1];
         end
         tbl[1] <= new_ent;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= 4'd0;
      end else if (redirect) begin
         flush_cnt <= FLUSH_LOAD;
      end else if (flush_cnt != 4'd0) begin
         flush_cnt <= flush_cnt - 4'd1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= 32'd0;
         flush_count <= 32'd0;
      end else begin
         if (stall_id) stall_count <= stall_count + 32'd1;
         if (redirect) flush_count <= flush_count + 32'd1;
      end
   end
`else
   assign stall_count = 32'd0;
   assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (defaults: 2 src, 2 stages).
// Perf counter expectations follow HAZARD_PERF_EN.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [9:0]  id_rs_addr;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd_addr;
   logic        id_rd_we;
   logic        id_is_load;
   logic        redirect;
   logic [3:0]  fwd_sel;
   logic        stall_id;
   logic        flush_id;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   int errors = 0;
   int checks = 0;

`ifdef HAZARD_PERF_EN
   localparam logic [31:0] PERF = 32'd1;
`else
   localparam logic [31:0] PERF = 32'd0;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs_addr  (id_rs_addr),
      .id_rs_used  (id_rs_used),
      .id_rd_addr  (id_rd_addr),
      .id_rd_we    (id_rd_we),
      .id_is_load  (id_is_load),
      .redirect    (redirect),
      .fwd_sel     (fwd_sel),
      .stall_id    (stall_id),
      .flush_id    (flush_id),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic drive(input logic       v,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic [1:0] used,
                        input logic [4:0] rd,
                        input logic       we,
                        input logic       ld);
      id_valid   = v;
      id_rs_addr = {rs2, rs1};
      id_rs_used = used;
      id_rd_addr = rd;
      id_rd_we   = we;
      id_is_load = ld;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst_n    = 1'b0;
      redirect = 1'b1;
      idle();
      #12;
      chk("rst_fwd",   32'(fwd_sel),  32'h0);
      chk("rst_stall", 32'(stall_id), 32'h0);
      chk("rst_flush", 32'(flush_id), 32'h0);
      chk("rst_scnt",  stall_count,   32'h0);
      chk("rst_fcnt",  flush_count,   32'h0);
      redirect = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: ADD x5 ; ADD x6,x5,x5
      drive(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0);
      settle();
      chk("s1_empty", 32'(fwd_sel), 32'h0);
      tick();
      drive(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0);
      settle();
      chk("s1_fwd",   32'(fwd_sel),  32'h5);
      chk("s1_stall", 32'(stall_id), 32'h0);
      tick();
      idle();
      tick();
      tick();

      // 2: LW x7 ; ADD x8,x7,x0
      drive(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1);
      tick();
      drive(1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0);
      settle();
      chk("s2_stall1", 32'(stall_id), 32'h1);
      chk("s2_fwd1",   32'(fwd_sel),  32'h1);
      tick();
      settle();
      chk("s2_stall2", 32'(stall_id), 32'h0);
      chk("s2_fwd2",   32'(fwd_sel),  32'h2);
      chk("s2_scnt",   stall_count,   PERF);
      tick();
      idle();
      tick();
      tick();

      // 3: x0 writes and unused sources
      drive(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 0);
      tick();
      drive(1, 5'd0, 5'd0, 2'b11, 5'd10, 1, 0);
      settle();
      chk("s3_x0", 32'(fwd_sel), 32'h0);
      tick();
      drive(1, 5'd3, 5'd10, 2'b01, 5'd0, 0, 0);
      settle();
      chk("s3_unused", 32'(fwd_sel), 32'h0);
      id_rs_used = 2'b11;
      settle();
      chk("s3_used", 32'(fwd_sel), 32'h4);
      id_valid = 1'b0;
      settle();
      chk("s3_novalid", 32'(fwd_sel), 32'h0);
      tick();
      idle();
      tick();
      tick();

      // 4: x9 at distance 1 and 2, then drains
      drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 0);
      tick();
      tick();
      drive(1, 5'd9, 5'd0, 2'b01, 5'd0, 0, 0);
      settle();
      chk("s4_young", 32'(fwd_sel), 32'h1);
      tick();
      settle();
      chk("s4_bub1", 32'(fwd_sel), 32'h2);
      tick();
      settle();
      chk("s4_bub2", 32'(fwd_sel), 32'h0);
      tick();
      settle();
      chk("s4_bub3", 32'(fwd_sel), 32'h0);
      idle();
      tick();

      // 5: redirect trains
      drive(1, 5'd0, 5'd0, 2'b00, 5'd12, 1, 0);
      redirect = 1'b1;
      settle();
      chk("s5_f0", 32'(flush_id), 32'h1);
      tick();
      redirect = 1'b0;
      drive(1, 5'd12, 5'd0, 2'b01, 5'd0, 0, 0);
      settle();
      chk("s5_f1",    32'(flush_id), 32'h1);
      chk("s5_nofwd", 32'(fwd_sel),  32'h0);
      chk("s5_fcnt",  flush_count,   PERF);
      tick();
      settle();
      chk("s5_f2", 32'(flush_id), 32'h0);
      idle();
      redirect = 1'b1;
      settle();
      chk("s5_e0", 32'(flush_id), 32'h1);
      tick();
      settle();
      chk("s5_e1", 32'(flush_id), 32'h1);
      tick();
      redirect = 1'b0;
      settle();
      chk("s5_e2", 32'(flush_id), 32'h1);
      tick();
      settle();
      chk("s5_e3", 32'(flush_id), 32'h0);
      tick();

      // 6a: load-use and redirect together
      drive(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1);
      tick();
      drive(1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0);
      redirect = 1'b1;
      settle();
      chk("s6_flush", 32'(flush_id), 32'h1);
      chk("s6_stall", 32'(stall_id), 32'h0);
      chk("s6_fwd",   32'(fwd_sel),  32'h1);
      tick();
      redirect = 1'b0;
      settle();
      chk("s6_fwd2",  32'(fwd_sel),  32'h2);
      chk("s6_flsh2", 32'(flush_id), 32'h1);
      tick();
      idle();
      tick();
      tick();

      // 6b: reset in the middle of a stall
      drive(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1);
      tick();
      drive(1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0);
      settle();
      chk("s6_pre", 32'(stall_id), 32'h1);
      rst_n    = 1'b0;
      redirect = 1'b1;
      #1;
      chk("s6_rst_stall", 32'(stall_id), 32'h0);
      chk("s6_rst_fwd",   32'(fwd_sel),  32'h0);
      chk("s6_rst_flush", 32'(flush_id), 32'h0);
      chk("s6_rst_scnt",  stall_count,   32'h0);
      chk("s6_rst_fcnt",  flush_count,   32'h0);
      redirect = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      settle();
      chk("s6_post_fwd",   32'(fwd_sel),  32'h0);
      chk("s6_post_stall", 32'(stall_id), 32'h0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
